apb_cfg_loader: RTL and testbench

APB_CFG_LOADER -- requirements
Module: apb_cfg_loader

---
 rtl/apb_cfg_loader.sv | 130 +++++++++++++
 tb/tb_apb_cfg_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cfg_loader.sv
// Walks a combinational config table and writes each entry over APB; 4 cycles/entry with a 1-wait slave.
// Slave stalls hold the transfer until PREADY or TIMEOUT ACCESS cycles; i_abort ends the run after the current transfer.
module apb_cfg_loader #(
   parameter int ADDR_WIDTH  = 10,
   parameter int NUM_ENTRIES = 29,
   parameter int TIMEOUT     = 15
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_start,
   input  logic                  i_abort,
   output logic [5:0]            o_tbl_idx,
   input  logic [ADDR_WIDTH-1:0] i_tbl_paddr,
   input  logic [31:0]           i_tbl_pwdata,
   output logic [ADDR_WIDTH-1:0] o_PADDR,
   output logic                  o_PSEL,
   output logic                  o_PENABLE,
   output logic                  o_PWRITE,
   output logic [31:0]           o_PWDATA,
   input  logic                  i_PREADY,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [1:0]            o_err,
   output logic [5:0]            o_cnt
);

   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
   localparam logic [5:0]    IDX_LAST  = 6'(NUM_ENTRIES - 1);
   localparam logic [1:0]    ERR_OK      = 2'b00;
   localparam logic [1:0]    ERR_TIMEOUT = 2'b01;
   localparam logic [1:0]    ERR_ABORT   = 2'b10;

   typedef enum logic [2:0] {IDLE, FETCH, SETUP, ACCESS, DONE} state_t;

   state_t         state;
   logic           abort_pend;
   logic [WW-1:0]  wait_cnt;
   logic           abort_now;

   // An abort raised in the very cycle it is checked counts as pending.
   assign abort_now = abort_pend | i_abort;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         abort_pend <= 1'b0;
         wait_cnt   <= '0;
         o_tbl_idx  <= '0;
         o_PADDR    <= '0;
         o_PWDATA   <= '0;
         o_PSEL     <= 1'b0;
         o_PENABLE  <= 1'b0;
         o_PWRITE   <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_err      <= ERR_OK;
         o_cnt      <= '0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  o_tbl_idx  <= '0;
                  o_cnt      <= '0;
                  o_err      <= ERR_OK;
                  o_busy     <= 1'b1;
                  abort_pend <= 1'b0;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               if (abort_now) begin
                  o_err  <= ERR_ABORT;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  state  <= DONE;
               end else begin
                  o_PADDR  <= i_tbl_paddr;
                  o_PWDATA <= i_tbl_pwdata;
                  o_PSEL   <= 1'b1;
                  o_PWRITE <= 1'b1;
                  wait_cnt <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (i_abort) abort_pend <= 1'b1;
               o_PENABLE <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (i_PREADY) begin
                  o_cnt     <= o_cnt + 6'd1;
                  o_PSEL    <= 1'b0;
                  o_PENABLE <= 1'b0;
                  o_PWRITE  <= 1'b0;
                  if (abort_now || o_tbl_idx == IDX_LAST) begin
                     if (abort_now) o_err <= ERR_ABORT;
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                     state  <= DONE;
                  end else begin
                     o_tbl_idx <= o_tbl_idx + 6'd1;
                     state     <= FETCH;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  // Timeout wins over a pending abort.
                  o_err     <= ERR_TIMEOUT;
                  o_PSEL    <= 1'b0;
                  o_PENABLE <= 1'b0;
                  o_PWRITE  <= 1'b0;
                  o_busy    <= 1'b0;
                  o_done    <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  if (i_abort) abort_pend <= 1'b1;
               end
            end
            DONE: begin
               abort_pend <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cfg_loader.sv
// Bench for apb_cfg_loader: table model, registered-PREADY slave and write scoreboard.
module tb_apb_cfg_loader;

   localparam int AW = 10;
   localparam int N  = 29;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          i_start = 1'b0;
   logic          i_abort = 1'b0;
   logic [5:0]    o_tbl_idx;
   logic [AW-1:0] i_tbl_paddr;
   logic [31:0]   i_tbl_pwdata;
   logic [AW-1:0] o_PADDR;
   logic          o_PSEL, o_PENABLE, o_PWRITE;
   logic [31:0]   o_PWDATA;
   logic          i_PREADY;
   logic          o_busy, o_done;
   logic [1:0]    o_err;
   logic [5:0]    o_cnt;

   apb_cfg_loader #(.ADDR_WIDTH(AW), .NUM_ENTRIES(N), .TIMEOUT(15)) dut (
      .clk(clk), .rstn(rstn), .i_start(i_start), .i_abort(i_abort),
      .o_tbl_idx(o_tbl_idx), .i_tbl_paddr(i_tbl_paddr), .i_tbl_pwdata(i_tbl_pwdata),
      .o_PADDR(o_PADDR), .o_PSEL(o_PSEL), .o_PENABLE(o_PENABLE), .o_PWRITE(o_PWRITE),
      .o_PWDATA(o_PWDATA), .i_PREADY(i_PREADY), .o_busy(o_busy), .o_done(o_done),
      .o_err(o_err), .o_cnt(o_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] tbl_addr(input logic [5:0] i);
      return 10'h040 + 10'({i, 2'b00});
   endfunction

   function automatic logic [31:0] tbl_data(input logic [5:0] i);
      return {16'hC0DE, 2'b01, i, 2'b10, ~i};
   endfunction

   assign i_tbl_paddr  = tbl_addr(o_tbl_idx);
   assign i_tbl_pwdata = tbl_data(o_tbl_idx);

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave answers one cycle after PSEL&PENABLE, except for entries at or beyond stall_idx.
   logic pready_r = 1'b0;
   logic stray = 1'b0;
   int   stall_idx = 64;
   always @(posedge clk)
      pready_r <= o_PSEL && o_PENABLE && !pready_r && (int'(o_tbl_idx) < stall_idx);
   assign i_PREADY = pready_r | stray;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;
   wr_t         sb[$];
   logic [31:0] mem [0:(1<<AW)-1];

   always @(negedge clk) begin
      if (rstn && o_PSEL && o_PENABLE && i_PREADY) begin
         mem[o_PADDR] = o_PWDATA;
         if (sb.size() == 0) chk("sb_extra_write", 64'd1, 64'd0);
         else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", 64'(o_PADDR), 64'(e.a));
            chk("wr_data", 64'(o_PWDATA), 64'(e.d));
         end
      end
   end

   int cyc = 0, c0 = 0, done_cnt = 0, done_rel = 0, psel_cnt = 0, acc_idx_cnt = 0;
   int mon_idx = 63;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (o_done) begin
         done_cnt++;
         done_rel = cyc - c0;
      end
      if (o_PSEL) psel_cnt++;
      if (o_PSEL && o_PENABLE && int'(o_tbl_idx) == mon_idx) acc_idx_cnt++;
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic push_exp(input int n);
      for (int i = 0; i < n; i++) sb.push_back('{a: tbl_addr(6'(i)), d: tbl_data(6'(i))});
   endtask

   task automatic start_run(input int n_exp);
      push_exp(n_exp);
      c0 = cyc;
      i_start = 1'b1;
      tick;
      i_start = 1'b0;
   endtask

   task automatic goto_rel(input int r);
      while (cyc - c0 < r) tick;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!o_done && n < budget) begin
         tick;
         n++;
      end
      if (!o_done) chk({tag, "_no_done"}, 64'd0, 64'd1);
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({o_PADDR, o_PWDATA, o_tbl_idx, o_cnt, o_err, o_busy, o_done,
                  o_PSEL, o_PENABLE, o_PWRITE});
   endfunction

   initial begin
      int d0, a0, p0;

      tick;
      chk("reset_outs", all_outs(), 64'd0);
      rstn = 1'b1;
      tick;
      tick;

      // Nominal run
      d0 = done_cnt;
      start_run(N);
      chk("nom_busy", 64'(o_busy), 64'd1);
      goto_rel(2);
      chk("nom_setup_ctl", 64'({o_PSEL, o_PENABLE, o_PWRITE}), 64'b101);
      chk("nom_setup_addr", 64'(o_PADDR), 64'(tbl_addr(6'd0)));
      goto_rel(3);
      chk("nom_access_ctl", 64'({o_PSEL, o_PENABLE, o_PWRITE}), 64'b111);
      goto_rel(50);
      chk("nom_cnt_mid", 64'(o_cnt), 64'd12);
      wait_done("nom", 200);
      chk("nom_done_cycle", 64'(done_rel), 64'd117);
      chk("nom_cnt", 64'(o_cnt), 64'd29);
      chk("nom_err", 64'(o_err), 64'd0);
      chk("nom_busy_done", 64'(o_busy), 64'd0);
      tick;
      chk("nom_done_pulses", 64'(done_cnt - d0), 64'd1);
      chk("nom_cnt_hold", 64'(o_cnt), 64'd29);
      chk("nom_sb_left", 64'(sb.size()), 64'd0);
      for (int i = 0; i < N; i++) chk("slave_reg", 64'(mem[tbl_addr(6'(i))]), 64'(tbl_data(6'(i))));

      // Stray PREADY during SETUP of entry 7
      start_run(N);
      goto_rel(30);
      chk("stray_setup", 64'({o_PSEL, o_PENABLE, o_tbl_idx}), 64'({2'b10, 6'd7}));
      stray = 1'b1;
      @(posedge clk);
      #1;
      stray = 1'b0;
      tick;
      chk("stray_cnt", 64'(o_cnt), 64'd7);
      chk("stray_access", 64'({o_PSEL, o_PENABLE}), 64'b11);
      wait_done("stray", 200);
      chk("stray_done_cycle", 64'(done_rel), 64'd117);
      chk("stray_cnt_end", 64'(o_cnt), 64'd29);
      tick;

      // Timeout on entry 3
      stall_idx = 3;
      mon_idx = 3;
      a0 = acc_idx_cnt;
      d0 = done_cnt;
      start_run(3);
      wait_done("tmo", 200);
      chk("tmo_done_cycle", 64'(done_rel), 64'd30);
      chk("tmo_err", 64'(o_err), 64'd1);
      chk("tmo_cnt", 64'(o_cnt), 64'd3);
      chk("tmo_access_cycles", 64'(acc_idx_cnt - a0), 64'd15);
      chk("tmo_psel", 64'({o_PSEL, o_PENABLE}), 64'd0);
      tick;
      chk("tmo_done_pulses", 64'(done_cnt - d0), 64'd1);
      chk("tmo_sb_left", 64'(sb.size()), 64'd0);
      stall_idx = 64;
      mon_idx = 63;

      // Abort during ACCESS of entry 5
      start_run(6);
      goto_rel(23);
      chk("abt_acc_idx", 64'({o_PENABLE, o_tbl_idx}), 64'({1'b1, 6'd5}));
      i_abort = 1'b1;
      tick;
      i_abort = 1'b0;
      wait_done("abt_acc", 50);
      chk("abt_acc_done_cycle", 64'(done_rel), 64'd25);
      chk("abt_acc_cnt", 64'(o_cnt), 64'd6);
      chk("abt_acc_err", 64'(o_err), 64'd2);
      tick;
      chk("abt_acc_sb_left", 64'(sb.size()), 64'd0);

      // Abort during FETCH of entry 2
      start_run(2);
      goto_rel(9);
      chk("abt_fetch_state", 64'({o_busy, o_PSEL, o_tbl_idx}), 64'({2'b10, 6'd2}));
      p0 = psel_cnt;
      i_abort = 1'b1;
      tick;
      i_abort = 1'b0;
      chk("abt_fetch_done", 64'(o_done), 64'd1);
      chk("abt_fetch_err", 64'(o_err), 64'd2);
      chk("abt_fetch_cnt", 64'(o_cnt), 64'd2);
      goto_rel(20);
      chk("abt_fetch_no_psel", 64'(psel_cnt - p0), 64'd0);
      chk("abt_fetch_sb_left", 64'(sb.size()), 64'd0);

      // i_start held high through a whole run
      d0 = done_cnt;
      push_exp(N);
      c0 = cyc;
      i_start = 1'b1;
      for (int n = 0; n < 200 && !o_done; n++) begin
         tick;
         if (cyc - c0 == 50) chk("busy_start_cnt_mid", 64'(o_cnt), 64'd12);
      end
      i_start = 1'b0;
      if (!o_done) chk("busy_start_no_done", 64'd0, 64'd1);
      chk("busy_start_done_cycle", 64'(done_rel), 64'd117);
      chk("busy_start_cnt", 64'(o_cnt), 64'd29);
      chk("busy_start_err", 64'(o_err), 64'd0);
      tick;
      tick;
      chk("busy_start_idle", 64'({o_busy, o_cnt}), 64'({1'b0, 6'd29}));
      chk("busy_start_done_pulses", 64'(done_cnt - d0), 64'd1);

      // Reset in ACCESS of entry 4, then a clean restart
      start_run(N);
      goto_rel(19);
      chk("rst_pre_access", 64'({o_PENABLE, o_tbl_idx}), 64'({1'b1, 6'd4}));
      #1;
      rstn = 1'b0;
      #1;
      chk("rst_mid_outs", all_outs(), 64'd0);
      sb.delete();
      tick;
      rstn = 1'b1;
      tick;
      start_run(N);
      goto_rel(2);
      chk("rst_restart_addr", 64'({o_PSEL, o_tbl_idx, o_PADDR}), 64'({1'b1, 6'd0, tbl_addr(6'd0)}));
      wait_done("rst_restart", 200);
      chk("rst_restart_done_cycle", 64'(done_rel), 64'd117);
      chk("rst_restart_cnt", 64'(o_cnt), 64'd29);
      chk("rst_restart_err", 64'(o_err), 64'd0);
      tick;
      chk("rst_restart_sb_left", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
